// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch FSM state encoding, datapath widths and PC legality helper.
package cpu_pkg;
  localparam int INSTR_W = 32;
  localparam int ADDR_W = 64;
  typedef enum logic {RUN = 1'b0, FAULT = 1'b1} fetch_state_e;
  // Legal PC: word aligned and the whole 4-byte word lies inside the ROM.
  // Compared as pc <= size-4 so a PC near 2^64 cannot wrap pc+3 into range.
  function automatic logic pc_legal(input logic [ADDR_W-1:0] pc, input int unsigned size);
    return (pc[1:0] == 2'b00) && (pc <= ADDR_W'(size - 4));
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular fetch buffer with push/pop/flush and an occupancy count.
// Ports: clk, reset (sync, active-high); push/pop/flush controls; din tail write
// data; dout head entry (combinational from storage); count occupancy.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 96
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [PW:0] count_q, count_d;
  always_comb count_d = flush ? '0 : count_q + (PW+1)'(push) - (PW+1)'(pop);
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      count_q <= count_d;
      if (flush) begin
        head_q <= '0;
        tail_q <= '0;
      end else begin
        if (push) tail_q <= tail_q + PW'(1);
        if (pop) head_q <= head_q + PW'(1);
      end
    end
  end
  // Storage is deliberately not reset; entries are don't-care while invalid.
  always_ff @(posedge clk)
    if (push && !flush && !reset) mem_q[tail_q] <= din;
  assign dout = mem_q[head_q];
  assign count = count_q;
endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: PC/FSM driving an instruction ROM into a decoupling fetch buffer.
// Ports: clk, reset (sync, active-high); imem_addr/imem_instr ROM interface;
// redirect_valid/redirect_target branch redirect; out_valid/out_ready/out_instr/
// out_pc decode handshake; fault set while fetch is halted on an illegal PC.
module fetch_controller
  import cpu_pkg::*;
#(
  parameter int IMEM_SIZE = 1024,
  parameter int BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               fault
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam int EW = ADDR_W + INSTR_W;
  fetch_state_e state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [CW-1:0] count;
  logic [EW-1:0] head;
  logic legal, push, pop;
  assign legal = pc_legal(pc_q, IMEM_SIZE);
  assign out_valid = count != '0;
  // Redirect wins over everything: no pop is consumed and nothing is pushed.
  assign pop = out_valid && out_ready && !redirect_valid;
  assign push = !redirect_valid && state_q == RUN && legal && (count < CW'(BUF_DEPTH) || pop);
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= '0;
      state_q <= RUN;
    end else if (redirect_valid) begin
      pc_q <= redirect_target;
      state_q <= pc_legal(redirect_target, IMEM_SIZE) ? RUN : FAULT;
    end else if (state_q == RUN) begin
      if (!legal) state_q <= FAULT;
      else if (push) pc_q <= pc_q + ADDR_W'(4);
    end
  end
  fetch_fifo #(.DEPTH(BUF_DEPTH), .W(EW)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .flush(redirect_valid),
    .din({pc_q, imem_instr}),
    .dout(head),
    .count(count)
  );
  assign imem_addr = pc_q;
  assign out_pc = head[EW-1:INSTR_W];
  assign out_instr = head[INSTR_W-1:0];
  assign fault = state_q == FAULT;
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed self-checking bench for fetch_controller.
module tb_fetch_controller;
  logic clk = 0, reset = 1, redirect_valid = 0, out_ready = 0;
  logic [63:0] redirect_target = '0;
  logic [63:0] imem_addr, out_pc;
  logic [31:0] imem_instr, out_instr;
  logic out_valid, fault;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  assign imem_instr = imem_addr[33:2];
  fetch_controller #(.IMEM_SIZE(1024), .BUF_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .fault(fault)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    step();
    step();
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_fault", 64'(fault), 0);
    chk("rst_addr", imem_addr, 0);
    reset = 0;
    out_ready = 1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("seq_valid", 64'(out_valid), 1);
      chk("seq_pc", out_pc, 64'(4 * k));
      chk("seq_instr", 64'(out_instr), 64'(k));
      chk("seq_addr", imem_addr, 64'(4 * k + 4));
    end
    out_ready = 0;
    for (int k = 0; k < 5; k++) step();
    chk("stall_head", out_pc, 16);
    chk("stall_pc", imem_addr, 24);
    chk("stall_valid", 64'(out_valid), 1);
    out_ready = 1;
    step();
    chk("drain0", out_pc, 20);
    step();
    chk("drain1", out_pc, 24);
    chk("drain1_instr", 64'(out_instr), 6);
    redirect_valid = 1;
    redirect_target = 64'h40;
    step();
    redirect_valid = 0;
    chk("redir_flush", 64'(out_valid), 0);
    chk("redir_addr", imem_addr, 64'h40);
    step();
    chk("redir_pc", out_pc, 64'h40);
    chk("redir_instr", 64'(out_instr), 64'h10);
    redirect_valid = 1;
    redirect_target = 64'h42;
    step();
    redirect_valid = 0;
    chk("mis_fault", 64'(fault), 1);
    chk("mis_valid", 64'(out_valid), 0);
    step();
    chk("mis_nopush", 64'(out_valid), 0);
    chk("mis_hold", imem_addr, 64'h42);
    redirect_valid = 1;
    redirect_target = 64'h10;
    step();
    redirect_valid = 0;
    chk("rec_fault", 64'(fault), 0);
    chk("rec_addr", imem_addr, 64'h10);
    step();
    chk("rec_pc", out_pc, 64'h10);
    out_ready = 0;
    redirect_valid = 1;
    redirect_target = 64'd1012;
    step();
    redirect_valid = 0;
    step();
    step();
    chk("end_full_pc", imem_addr, 1020);
    out_ready = 1;
    step();
    chk("end_head0", out_pc, 1016);
    chk("end_addr", imem_addr, 1024);
    chk("end_nofault", 64'(fault), 0);
    step();
    chk("end_head1", out_pc, 1020);
    chk("end_instr", 64'(out_instr), 255);
    chk("end_fault", 64'(fault), 1);
    chk("end_hold", imem_addr, 1024);
    step();
    chk("end_drained", 64'(out_valid), 0);
    chk("end_fault2", 64'(fault), 1);
    out_ready = 0;
    redirect_valid = 1;
    redirect_target = 64'h100;
    step();
    redirect_valid = 0;
    step();
    step();
    chk("pre_rst_valid", 64'(out_valid), 1);
    chk("pre_rst_pc", out_pc, 64'h100);
    chk("pre_rst_addr", imem_addr, 64'h108);
    reset = 1;
    redirect_valid = 1;
    redirect_target = 64'h200;
    out_ready = 1;
    step();
    chk("rst2_addr", imem_addr, 0);
    chk("rst2_valid", 64'(out_valid), 0);
    chk("rst2_fault", 64'(fault), 0);
    reset = 0;
    redirect_valid = 0;
    step();
    chk("post_rst_pc", out_pc, 0);
    chk("post_rst_valid", 64'(out_valid), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
